// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the SHA-256 round sequencer.
// Imported by the controller, its fetch unit and its interface.
package sha_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUNDS,
        S_UPDATE,
        S_DONE,
        S_WAIT_CLR
    } state_t;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int NUM_ROUNDS      = 64;
    localparam int RIDX_W          = 6;
    localparam int WIDX_W          = 4;

endpackage

// File: rtl/sha_round_ctrl_if.sv
// Control bundle between go latch, message memory, round datapath
// and the round sequencer (master = sequencer side).
interface sha_round_ctrl_if #(
    parameter int BLK_W  = 8,
    parameter int ADDR_W = BLK_W + 4
);
    import sha_ctrl_pkg::*;

    logic              enable;
    logic [BLK_W-1:0]  num_blocks;
    logic              msg_rd;
    logic [ADDR_W-1:0] msg_addr;
    logic              w_load;
    logic [WIDX_W-1:0] w_idx;
    logic              init_hash;
    logic              round_en;
    logic [RIDX_W-1:0] round_idx;
    logic              digest_update;
    logic              restart;
    logic              busy;

    modport master (
        input  enable, num_blocks,
        output msg_rd, msg_addr, w_load, w_idx,
        output init_hash, round_en, round_idx,
        output digest_update, restart, busy
    );

    modport slave (
        output enable, num_blocks,
        input  msg_rd, msg_addr, w_load, w_idx,
        input  init_hash, round_en, round_idx,
        input  digest_update, restart, busy
    );

endinterface

// File: rtl/sha_msg_fetch.sv
// Message word fetch: word counter, address generation and the
// one-cycle read-to-capture delay for the schedule registers.
module sha_msg_fetch
    import sha_ctrl_pkg::*;
#(
    parameter int BLK_W  = 8,
    parameter int ADDR_W = BLK_W + 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BLK_W-1:0]  block_idx,
    output logic              msg_rd,
    output logic [ADDR_W-1:0] msg_addr,
    output logic              w_load,
    output logic [WIDX_W-1:0] w_idx,
    output logic              last_word
);

    logic              rd;
    logic [WIDX_W-1:0] word;

    assign last_word = rd && (word == WIDX_W'(WORDS_PER_BLOCK - 1));
    assign msg_rd    = rd;
    assign msg_addr  = rd ? {block_idx, word} : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd     <= 1'b0;
            word   <= '0;
            w_load <= 1'b0;
            w_idx  <= '0;
        end else begin
            // read data lands next cycle, so capture trails the strobe
            w_load <= rd;
            w_idx  <= word;
            if (start) begin
                rd   <= 1'b1;
                word <= '0;
            end else if (abort || last_word) begin
                rd   <= 1'b0;
                word <= '0;
            end else if (rd) begin
                word <= word + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA-256 multi-block sequencer: fetch 16 words, run 64 rounds,
// update the digest per block, then pulse restart to the go latch.
module sha_round_ctrl
    import sha_ctrl_pkg::*;
#(
    parameter int BLK_W  = 8,
    parameter int ADDR_W = BLK_W + 4
) (
    input logic              clock,
    input logic              reset,
    sha_round_ctrl_if.master bus
);

    state_t            state;
    logic [BLK_W-1:0]  blk;
    logic [BLK_W-1:0]  nblk;
    logic [BLK_W:0]    blk_nx;
    logic [RIDX_W-1:0] ridx;
    logic              more;
    logic              start;
    logic              abort;
    logic              last_word;

    // one extra bit so a full count of 2^BLK_W-1 never wraps
    assign blk_nx = {1'b0, blk} + {{BLK_W{1'b0}}, 1'b1};
    assign more   = blk_nx < {1'b0, nblk};

    assign start = bus.enable &&
                   ((state == S_IDLE && bus.num_blocks != '0) ||
                    (state == S_UPDATE && more));
    assign abort = !bus.enable && (state == S_LOAD);

    sha_msg_fetch #(
        .BLK_W  (BLK_W),
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .block_idx (blk),
        .msg_rd    (bus.msg_rd),
        .msg_addr  (bus.msg_addr),
        .w_load    (bus.w_load),
        .w_idx     (bus.w_idx),
        .last_word (last_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            blk   <= '0;
            nblk  <= '0;
            ridx  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        nblk  <= bus.num_blocks;
                        blk   <= '0;
                        state <= (bus.num_blocks == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!bus.enable) begin
                        state <= S_IDLE;
                    end else if (last_word) begin
                        state <= S_ROUNDS;
                        ridx  <= '0;
                    end
                end
                S_ROUNDS: begin
                    if (!bus.enable) begin
                        state <= S_IDLE;
                        ridx  <= '0;
                    end else if (ridx == RIDX_W'(NUM_ROUNDS - 1)) begin
                        state <= S_UPDATE;
                        ridx  <= '0;
                    end else begin
                        ridx <= ridx + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (!bus.enable) begin
                        state <= S_IDLE;
                    end else if (more) begin
                        blk   <= blk_nx[BLK_W-1:0];
                        state <= S_LOAD;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    if (!bus.enable) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = (state != S_IDLE);
    assign bus.restart       = (state == S_DONE);
    assign bus.digest_update = (state == S_UPDATE);
    assign bus.round_en      = (state == S_ROUNDS);
    assign bus.round_idx     = ridx;
    // word 0 of block 0 is the only address-zero read of a run
    assign bus.init_hash     = bus.msg_rd && (bus.msg_addr == '0);

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Bench for sha_round_ctrl: timeline reference model, per-cycle
// compare process, directed scenarios and randomized runs.
module tb_sha_round_ctrl;
    import sha_ctrl_pkg::*;

    localparam int BLK_W   = 8;
    localparam int PER_BLK = 81;

    logic clock = 1'b0;
    logic reset = 1'b0;

    sha_round_ctrl_if #(.BLK_W(BLK_W)) bus ();

    sha_round_ctrl #(.BLK_W(BLK_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef enum {M_IDLE, M_RUN, M_WAIT} mode_t;

    typedef struct {
        logic rd;
        int   addr;
        logic ih;
        logic ren;
        int   ridx;
        logic dig;
        logic rst;
        logic busy;
    } exp_t;

    mode_t mode   = M_IDLE;
    int    t      = 0;
    int    n      = 0;
    logic  m_wl   = 1'b0;
    int    m_widx = 0;

    // t = cycles since the start sample; block b occupies t in
    // [81b+1, 81b+81]: 16 loads, 64 rounds, 1 update
    function automatic exp_t expect_now(mode_t md, int tt, int nn);
        exp_t e;
        int   blk;
        int   p;
        e = '{default: 0};
        if (md == M_WAIT) begin
            e.busy = 1'b1;
        end else if (md == M_RUN) begin
            e.busy = 1'b1;
            if (tt == PER_BLK * nn + 1) begin
                e.rst = 1'b1;
            end else begin
                blk = (tt - 1) / PER_BLK;
                p   = (tt - 1) % PER_BLK;
                if (p < 16) begin
                    e.rd   = 1'b1;
                    e.addr = blk * 16 + p;
                    e.ih   = (blk == 0 && p == 0);
                end else if (p < 80) begin
                    e.ren  = 1'b1;
                    e.ridx = p - 16;
                end else begin
                    e.dig = 1'b1;
                end
            end
        end
        return e;
    endfunction

    always @(posedge clock or negedge reset) begin
        exp_t prev;
        if (!reset) begin
            mode   = M_IDLE;
            t      = 0;
            n      = 0;
            m_wl   = 1'b0;
            m_widx = 0;
        end else begin
            prev   = expect_now(mode, t, n);
            m_wl   = prev.rd;
            m_widx = prev.addr % 16;
            case (mode)
                M_IDLE: begin
                    if (bus.enable) begin
                        n    = int'(bus.num_blocks);
                        t    = 1;
                        mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (t == PER_BLK * n + 1) mode = M_WAIT;
                    else if (!bus.enable) mode = M_IDLE;
                    else t++;
                end
                default: begin
                    if (!bus.enable) mode = M_IDLE;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        exp_t e;
        e = expect_now(mode, t, n);
        chk("busy", int'(bus.busy), int'(e.busy));
        chk("msg_rd", int'(bus.msg_rd), int'(e.rd));
        chk("init_hash", int'(bus.init_hash), int'(e.ih));
        chk("round_en", int'(bus.round_en), int'(e.ren));
        chk("digest_update", int'(bus.digest_update), int'(e.dig));
        chk("restart", int'(bus.restart), int'(e.rst));
        chk("w_load", int'(bus.w_load), int'(m_wl));
        if (e.rd) chk("msg_addr", int'(bus.msg_addr), e.addr);
        if (e.ren) chk("round_idx", int'(bus.round_idx), e.ridx);
        if (m_wl) chk("w_idx", int'(bus.w_idx), m_widx);
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clock);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_msg_rd"}, int'(bus.msg_rd), 0);
        chk({tag, "_msg_addr"}, int'(bus.msg_addr), 0);
        chk({tag, "_w_load"}, int'(bus.w_load), 0);
        chk({tag, "_w_idx"}, int'(bus.w_idx), 0);
        chk({tag, "_init_hash"}, int'(bus.init_hash), 0);
        chk({tag, "_round_en"}, int'(bus.round_en), 0);
        chk({tag, "_round_idx"}, int'(bus.round_idx), 0);
        chk({tag, "_digest"}, int'(bus.digest_update), 0);
        chk({tag, "_restart"}, int'(bus.restart), 0);
    endtask

    initial begin
        int rn;
        int ab;
        int hold;

        bus.enable     = 1'b0;
        bus.num_blocks = '0;
        tick(2);
        chk_all_zero("rst");
        reset = 1'b1;
        tick(2);

        // single block
        bus.num_blocks = 8'd1;
        bus.enable     = 1'b1;
        tick(1);
        bus.num_blocks = 8'd5;
        chk("b1_c1_rd", int'(bus.msg_rd), 1);
        chk("b1_c1_addr", int'(bus.msg_addr), 0);
        chk("b1_c1_ih", int'(bus.init_hash), 1);
        tick(1);
        chk("b1_c2_wl", int'(bus.w_load), 1);
        chk("b1_c2_widx", int'(bus.w_idx), 0);
        tick(14);
        chk("b1_c16_addr", int'(bus.msg_addr), 15);
        tick(1);
        chk("b1_c17_ren", int'(bus.round_en), 1);
        chk("b1_c17_ridx", int'(bus.round_idx), 0);
        chk("b1_c17_wl", int'(bus.w_load), 1);
        chk("b1_c17_widx", int'(bus.w_idx), 15);
        tick(63);
        chk("b1_c80_ridx", int'(bus.round_idx), 63);
        tick(1);
        chk("b1_c81_dig", int'(bus.digest_update), 1);
        tick(1);
        chk("b1_c82_rst", int'(bus.restart), 1);
        bus.enable = 1'b0;
        tick(2);
        chk("b1_idle", int'(bus.busy), 0);

        // two blocks
        bus.num_blocks = 8'd2;
        bus.enable     = 1'b1;
        tick(1);
        chk("b2_c1_ih", int'(bus.init_hash), 1);
        tick(81);
        chk("b2_c82_addr", int'(bus.msg_addr), 16);
        chk("b2_c82_ih", int'(bus.init_hash), 0);
        tick(15);
        chk("b2_c97_addr", int'(bus.msg_addr), 31);
        tick(65);
        chk("b2_c162_dig", int'(bus.digest_update), 1);
        tick(1);
        chk("b2_c163_rst", int'(bus.restart), 1);
        bus.enable = 1'b0;
        tick(2);

        // zero blocks
        bus.num_blocks = 8'd0;
        bus.enable     = 1'b1;
        tick(1);
        chk("b0_c1_rst", int'(bus.restart), 1);
        chk("b0_c1_rd", int'(bus.msg_rd), 0);
        bus.enable = 1'b0;
        tick(2);
        chk("b0_idle", int'(bus.busy), 0);

        // abort during round 30 of block 0
        bus.num_blocks = 8'd3;
        bus.enable     = 1'b1;
        tick(47);
        chk("ab_c47_ridx", int'(bus.round_idx), 30);
        bus.enable = 1'b0;
        tick(1);
        chk("ab_c48_busy", int'(bus.busy), 0);
        chk("ab_c48_ren", int'(bus.round_en), 0);
        tick(100);

        // enable stuck high after done
        bus.num_blocks = 8'd1;
        bus.enable     = 1'b1;
        tick(82);
        chk("st_c82_rst", int'(bus.restart), 1);
        tick(10);
        chk("st_wait_busy", int'(bus.busy), 1);
        chk("st_wait_rd", int'(bus.msg_rd), 0);
        bus.enable = 1'b0;
        tick(1);
        chk("st_idle", int'(bus.busy), 0);
        bus.enable = 1'b1;
        tick(1);
        chk("st_rerun_rd", int'(bus.msg_rd), 1);
        chk("st_rerun_addr", int'(bus.msg_addr), 0);
        tick(81);
        bus.enable = 1'b0;
        tick(2);

        // reset during block 1 word 7
        bus.num_blocks = 8'd2;
        bus.enable     = 1'b1;
        tick(89);
        chk("rm_c89_addr", int'(bus.msg_addr), 23);
        reset = 1'b0;
        #1;
        chk_all_zero("rm");
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rm_c1_ih", int'(bus.init_hash), 1);
        chk("rm_c1_addr", int'(bus.msg_addr), 0);
        tick(162);
        chk("rm_c163_rst", int'(bus.restart), 1);
        bus.enable = 1'b0;
        tick(2);

        // randomized runs, aborts and wait-clear holds
        for (int i = 0; i < 12; i++) begin
            rn   = $urandom_range(0, 3);
            ab   = (rn > 0 && $urandom_range(0, 1) == 1) ?
                   $urandom_range(1, PER_BLK * rn) : 0;
            hold = $urandom_range(0, 5);
            bus.num_blocks = 8'(rn);
            bus.enable     = 1'b1;
            tick(1);
            bus.num_blocks = 8'($urandom);
            if (ab > 0) begin
                tick(ab - 1);
                bus.enable = 1'b0;
                tick(3);
            end else begin
                tick(PER_BLK * rn);
                chk("rnd_rst", int'(bus.restart), 1);
                tick(hold);
                bus.enable = 1'b0;
                tick(2);
            end
            tick($urandom_range(1, 3));
        end

        // maximum block count must finish without wrap
        bus.num_blocks = 8'd255;
        bus.enable     = 1'b1;
        tick(PER_BLK * 254 + 1);
        chk("max_last_addr", int'(bus.msg_addr), 4064);
        tick(PER_BLK);
        chk("max_rst", int'(bus.restart), 1);
        bus.enable = 1'b0;
        tick(2);
        chk("max_idle", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_round_ctrl.md
# sha_round_ctrl

Sequencer that consumes the `enable` level from the go latch and drives one complete SHA-256 hash over a multi-block message: fetching each block's 16 message words, stepping 64 compression rounds and issuing the digest update. At the end it emits a one-cycle `restart` pulse back to the go latch, which clears `enable` and closes the start/finish handshake. It sits between the go latch, the message memory and the round datapath.

## Interface
- `BLK_W`, 8: width of the block count and block index.
- `ADDR_W`, BLK_W+4: message memory word address width (block*16 + word).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `enable`  in  1  run level from the go latch.
- `num_blocks`  in  BLK_W  512-bit block count; sampled in IDLE on start.
- `msg_rd`  out  1  message memory read strobe; read data is valid the next cycle.
- `msg_addr`  out  ADDR_W  word address for `msg_rd`.
- `w_load`  out  1  capture the memory read data into W[`w_idx`].
- `w_idx`  out  4  schedule slot for `w_load`.
- `init_hash`  out  1  load the IV into H and the working registers (first block only).
- `round_en`  out  1  advance one compression round.
- `round_idx`  out  6  current round, 0..63.
- `digest_update`  out  1  H += working variables.
- `restart`  out  1  one-cycle completion pulse to the go latch.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, ROUNDS, UPDATE, DONE, WAIT_CLR.
- IDLE:
  - enable=1 and num_blocks=0 → DONE.
  - enable=1 and num_blocks>0 → LOAD; latch num_blocks; block_idx=0; word=0.
- LOAD, 16 cycles:
  - msg_rd=1, msg_addr={block_idx, word}; word counts 0..15.
  - init_hash=1 in the first LOAD cycle of block 0 only.
  - After word 15 → ROUNDS with round_idx=0.
- w_load and w_idx are msg_rd and word delayed one cycle. The final w_load (idx 15) coincides with ROUNDS round 0, which is legal because W[15] is first needed at round 15.
- ROUNDS, 64 cycles: round_en=1; round_idx counts 0..63; after 63 → UPDATE.
- UPDATE, 1 cycle: digest_update=1.
  - block_idx+1 < latched count → LOAD, with block_idx+1 and word=0.
  - Otherwise → DONE.
- DONE, 1 cycle: restart=1 → WAIT_CLR.
- WAIT_CLR: hold until enable=0, then → IDLE. This prevents a re-run while the go latch is clearing.
- Abort: enable=0 in LOAD, ROUNDS or UPDATE → IDLE next cycle.
  - No restart, no digest_update in the exit cycle, and no further msg_rd.
  - The pending delayed w_load may still fire once and is harmless.
- Block counter is exactly BLK_W bits; num_blocks = 2^BLK_W−1 must complete without wrap.
- Reset asserted (low) at any time: state=IDLE and all outputs 0 immediately, without waiting for a clock edge. Counters are cleared.

## Timing
- Cycle 0 is the first cycle in which the FSM samples enable=1 in IDLE.
- Per block: 16 LOAD + 64 ROUNDS + 1 UPDATE = 81 cycles.
- For N blocks:
  - LOAD occupies cycles 1..16 of block 0.
  - restart=1 in cycle 81N+1; WAIT_CLR from cycle 81N+2.
  - N=0: restart=1 in cycle 1.
- msg_rd to w_load latency: exactly 1 cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from enable.
- Reset values: every output 0; round_idx=0; w_idx=0; msg_addr=0.

## Structure
- Package `sha_ctrl_pkg`:
  - state enum;
  - constants WORDS_PER_BLOCK=16 and NUM_ROUNDS=64;
  - round index width 6.
- One natural sub-module, `sha_msg_fetch`: holds the word counter, address generation and the one-cycle w_load/w_idx delay. The FSM drives it with start/abort and receives `last_word`.

## Test plan
- Single block: num_blocks=1, enable held.
  - msg_addr 0..15 on cycles 1..16; w_load idx 0..15 on cycles 2..17.
  - round_en on cycles 17..80; digest_update on 81; restart on 82.
- Two blocks: num_blocks=2.
  - Second LOAD on cycles 82..97 with msg_addr 16..31.
  - init_hash only in cycle 1; two digest_update pulses (81, 162); restart only in cycle 163.
- Zero blocks: num_blocks=0.
  - restart in cycle 1; no msg_rd, round_en or digest_update at all.
- Abort: drop enable during round 30 of block 0.
  - IDLE next cycle; busy=0; restart never pulses; digest_update never pulses.
- Enable stuck high after DONE: hold enable=1 for 10 cycles after restart.
  - FSM stays in WAIT_CLR with no new msg_rd.
  - Releasing enable → IDLE; re-asserting it starts a fresh run at msg_addr 0.
- Reset mid-operation: assert reset low during LOAD word 7 of block 1.
  - All outputs 0 immediately.
  - After release with enable=1, the run restarts at block 0 with init_hash=1.
